// File: rtl/error_recovery_ctrl.sv
// ---------------------------------------------------------------------------
// error_recovery_ctrl
//
// Purpose:
//   Reacts to the per-stage timing-error flags from the error detectors.
//   When any stage is flagged while idle, it:
//     1. captures the shadow-latch value of every flagged lane and zeroes
//        the unflagged lanes,
//     2. spends one RESTORE cycle driving restore_en/restore_data so the
//        pipeline reloads the flagged stages,
//     3. holds the pipeline frozen for REPLAY_CYCLES more cycles, then
//        releases it.
//   Error flags are ignored while a recovery is in progress.
//
//   It also keeps a saturating count of recovery events. A throttle request
//   is raised for a whole window when the previous window saw at least
//   THROTTLE_THRESH events.
//
// Ports:
//   clk           in   1                  system clock, rising edge
//   reset         in   1                  asynchronous, active-high
//   error         in   NUM_STAGES         per-stage error flag
//   shadow_data   in   NUM_STAGES*DATA_W  shadow values, lane i = [i*DATA_W +: DATA_W]
//   stall         out  1                  freeze pipeline advance
//   restore_en    out  NUM_STAGES         load restore_data lane into stage i
//   restore_data  out  NUM_STAGES*DATA_W  captured shadow values (0 in unflagged lanes)
//   recovering    out  1                  recovery in progress (same as stall)
//   err_count     out  ERR_CNT_W          saturating recovery-event count
//   throttle      out  1                  error-rate throttle request
//
// Every output comes straight from a register, so there is no
// combinational path from error to any output.
// ---------------------------------------------------------------------------
module error_recovery_ctrl #(
  parameter int NUM_STAGES      = 4,
  parameter int DATA_W          = 8,
  parameter int REPLAY_CYCLES   = 2,
  parameter int ERR_CNT_W       = 16,
  parameter int WINDOW          = 64,
  parameter int THROTTLE_THRESH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_STAGES-1:0]        error,
  input  logic [NUM_STAGES*DATA_W-1:0] shadow_data,
  output logic                         stall,
  output logic [NUM_STAGES-1:0]        restore_en,
  output logic [NUM_STAGES*DATA_W-1:0] restore_data,
  output logic                         recovering,
  output logic [ERR_CNT_W-1:0]         err_count,
  output logic                         throttle
);

  localparam int LANES_W = NUM_STAGES * DATA_W;
  localparam int RPL_W   = (REPLAY_CYCLES > 1) ? $clog2(REPLAY_CYCLES) : 1;
  localparam int WIN_W   = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam int EV_W    = $clog2(THROTTLE_THRESH + 1);

  localparam logic [RPL_W-1:0] RPL_LOAD = RPL_W'(REPLAY_CYCLES - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [EV_W-1:0]  EV_SAT   = EV_W'(THROTTLE_THRESH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESTORE = 2'd1,
    REPLAY  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [RPL_W-1:0]    rpl_cnt;
  logic [RPL_W-1:0]    rpl_cnt_nxt;
  logic [NUM_STAGES-1:0] restore_en_nxt;
  logic [LANES_W-1:0]  restore_data_nxt;
  logic                event_hit;
  logic                stall_nxt;

  logic [WIN_W-1:0]    win_cnt;
  logic [EV_W-1:0]     win_ev;
  logic                throttle_hit;

  // Keep the shadow value of every flagged lane, zero the rest.
  function automatic logic [LANES_W-1:0] capture_lanes(
    input logic [NUM_STAGES-1:0] flags,
    input logic [LANES_W-1:0]    lanes
  );
    logic [LANES_W-1:0] res;
    res = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (flags[i]) begin
        res[i*DATA_W +: DATA_W] = lanes[i*DATA_W +: DATA_W];
      end
    end
    return res;
  endfunction

  // Event counter sticks at all-ones instead of wrapping.
  function automatic logic [ERR_CNT_W-1:0] sat_inc_cnt(
    input logic [ERR_CNT_W-1:0] v
  );
    if (&v) begin
      return v;
    end
    return v + 1'b1;
  endfunction

  // Window event counter only needs to reach the threshold.
  function automatic logic [EV_W-1:0] sat_inc_ev(
    input logic [EV_W-1:0] v,
    input logic            inc
  );
    if (inc && (v < EV_SAT)) begin
      return v + 1'b1;
    end
    return v;
  endfunction

  // Next-state and next-output logic
  always_comb begin
    state_nxt        = state;
    rpl_cnt_nxt      = rpl_cnt;
    restore_en_nxt   = '0;
    restore_data_nxt = '0;
    event_hit        = 1'b0;
    case (state)
      IDLE: begin
        if (|error) begin
          event_hit        = 1'b1;
          state_nxt        = RESTORE;
          restore_en_nxt   = error;
          restore_data_nxt = capture_lanes(error, shadow_data);
        end
      end
      RESTORE: begin
        state_nxt   = REPLAY;
        rpl_cnt_nxt = RPL_LOAD;
      end
      REPLAY: begin
        if (rpl_cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          rpl_cnt_nxt = rpl_cnt - 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    stall_nxt = (state_nxt != IDLE);
  end

  // The event landing on the last window edge still counts toward that window.
  always_comb begin
    throttle_hit = ((int'(win_ev) + int'(event_hit)) >= THROTTLE_THRESH);
  end

  // Recovery FSM and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      rpl_cnt      <= '0;
      stall        <= 1'b0;
      recovering   <= 1'b0;
      restore_en   <= '0;
      restore_data <= '0;
      err_count    <= '0;
    end else begin
      state        <= state_nxt;
      rpl_cnt      <= rpl_cnt_nxt;
      stall        <= stall_nxt;
      recovering   <= stall_nxt;
      restore_en   <= restore_en_nxt;
      restore_data <= restore_data_nxt;
      if (event_hit) begin
        err_count <= sat_inc_cnt(err_count);
      end
    end
  end

  // Error-rate window
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_cnt  <= '0;
      win_ev   <= '0;
      throttle <= 1'b0;
    end else if (win_cnt == WIN_LAST) begin
      win_cnt  <= '0;
      win_ev   <= '0;
      throttle <= throttle_hit;
    end else begin
      win_cnt <= win_cnt + 1'b1;
      win_ev  <= sat_inc_ev(win_ev, event_hit);
    end
  end

endmodule
